// File: rtl/norm_shifter.sv
// norm_shifter -- two-stage normalising left shifter for FP fractions.
//
// Stage 1 registers the transaction and the leading-zero counts of the
// incoming fraction (whole word for FP32, one count per 10-bit lane for FP16).
// Stage 2 clamps each count against its limit, shifts, and registers the
// result plus flags. A valid/ready handshake runs on both ends.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake
//   fmt                       FP32 (one 26-bit lane) or FP16 (two 10-bit lanes)
//   din[25:0]                 FP32 full word; FP16 hi = [25:16], gap = [15:10], lo = [9:0]
//   lim[7:0]                  max left shift; FP32 lim[4:0]; FP16 hi lim[7:4], lo lim[3:0]
//   sticky_h_in, sticky_l_in  sideband bits carried alongside the transaction
//   out_valid / out_ready     output handshake
//   dout[25:0]                normalised fraction, same layout as din
//   shamt_h, shamt_l          applied shift per lane (FP32 uses shamt_l only)
//   zero_h, zero_l            lane input was all zero
//   sticky_h, sticky_l        registered sideband bits

package fpall_pkg;
    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;
endpackage

// Leading-zero counter. For an all-zero input cnt is W; callers use zero.
module ns_lzc #(
    parameter int W  = 10,
    parameter int CW = 4
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt,
    output logic          zero
);
    logic found;

    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (d[i]) found = 1'b1;
                else      cnt   = cnt + CW'(1);
            end
        end
    end

    assign zero = ~|d;
endmodule

// Clamped left shift for one lane. Bits shifted past the top of the lane
// are dropped; only leading zeros are ever shifted out, so nothing is lost.
module ns_shift #(
    parameter int W  = 10,
    parameter int CW = 4
) (
    input  logic [W-1:0]  d,
    input  logic [CW-1:0] lzc,
    input  logic [CW-1:0] lim,
    input  logic          zero,
    output logic [CW-1:0] shamt,
    output logic [W-1:0]  q
);
    always_comb begin
        shamt = '0;
        if (!zero) shamt = (lzc < lim) ? lzc : lim;
        q = d << shamt;
    end
endmodule

module norm_shifter
    import fpall_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  fp_fmt_e     fmt,
    input  logic [25:0] din,
    input  logic [7:0]  lim,
    input  logic        sticky_h_in,
    input  logic        sticky_l_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] dout,
    output logic [4:0]  shamt_h,
    output logic [4:0]  shamt_l,
    output logic        zero_h,
    output logic        zero_l,
    output logic        sticky_h,
    output logic        sticky_l
);
    localparam int NUM_LANES = 2;
    localparam int LANE_W    = 10;
    localparam int LCW       = 4;

    typedef struct packed {
        fp_fmt_e                        fmt;
        logic [25:0]                    din;
        logic [7:0]                     lim;
        logic                           sticky_h;
        logic                           sticky_l;
        logic [4:0]                     lzc_w;
        logic                           zero_w;
        logic [NUM_LANES-1:0][LCW-1:0]  lzc_n;
        logic [NUM_LANES-1:0]           zero_n;
    } s1_t;

    typedef struct packed {
        logic [25:0] dout;
        logic [4:0]  shamt_h;
        logic [4:0]  shamt_l;
        logic        zero_h;
        logic        zero_l;
        logic        sticky_h;
        logic        sticky_l;
    } s2_t;

    // vld_pipe_q[1] = stage-1 valid, vld_pipe_q[2] = stage-2 valid
    logic [2:1] vld_pipe_q, vld_pipe_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;

    logic s2_adv, s1_adv, accept;

    // Handshake: each stage moves when its downstream slot is free or
    // draining this cycle. in_ready depends only on state and out_ready.
    assign s2_adv   = ~vld_pipe_q[2] | out_ready;
    assign s1_adv   = ~vld_pipe_q[1] | s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid & in_ready;

    // ---------------- stage 1: leading-zero counts ----------------
    logic [NUM_LANES-1:0][LANE_W-1:0] in_lane;
    logic [NUM_LANES-1:0][LCW-1:0]    in_lzc_n;
    logic [NUM_LANES-1:0]             in_zero_n;
    logic [4:0]                       in_lzc_w;
    logic                             in_zero_w;

    assign in_lane = {din[25:16], din[9:0]};

    ns_lzc #(.W(26), .CW(5)) u_lzc_w (
        .d    (din),
        .cnt  (in_lzc_w),
        .zero (in_zero_w)
    );

    // ---------------- stage 2: clamp and shift ----------------
    logic [NUM_LANES-1:0][LANE_W-1:0] s1_lane;
    logic [NUM_LANES-1:0][LANE_W-1:0] q_n;
    logic [NUM_LANES-1:0][LCW-1:0]    sh_n;
    logic [25:0]                      q_w;
    logic [4:0]                       sh_w;

    assign s1_lane = {s1_q.din[25:16], s1_q.din[9:0]};

    ns_shift #(.W(26), .CW(5)) u_shift_w (
        .d     (s1_q.din),
        .lzc   (s1_q.lzc_w),
        .lim   (s1_q.lim[4:0]),
        .zero  (s1_q.zero_w),
        .shamt (sh_w),
        .q     (q_w)
    );

    // Lane 0 is the low FP16 half, lane 1 the high half.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ns_lzc #(.W(LANE_W), .CW(LCW)) u_lzc (
            .d    (in_lane[g]),
            .cnt  (in_lzc_n[g]),
            .zero (in_zero_n[g])
        );

        ns_shift #(.W(LANE_W), .CW(LCW)) u_shift (
            .d     (s1_lane[g]),
            .lzc   (s1_q.lzc_n[g]),
            .lim   (s1_q.lim[g*LCW +: LCW]),
            .zero  (s1_q.zero_n[g]),
            .shamt (sh_n[g]),
            .q     (q_n[g])
        );
    end

    // ---------------- next-state ----------------
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;

        if (s1_adv) vld_pipe_d[1] = in_valid;
        if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];

        if (accept) begin
            s1_d.fmt      = fmt;
            s1_d.din      = din;
            s1_d.lim      = lim;
            s1_d.sticky_h = sticky_h_in;
            s1_d.sticky_l = sticky_l_in;
            s1_d.lzc_w    = in_lzc_w;
            s1_d.zero_w   = in_zero_w;
            s1_d.lzc_n    = in_lzc_n;
            s1_d.zero_n   = in_zero_n;
        end

        // Output register only changes when a new item moves in, so it
        // holds steady while stalled.
        if (s2_adv && vld_pipe_q[1]) begin
            s2_d.sticky_h = s1_q.sticky_h;
            s2_d.sticky_l = s1_q.sticky_l;
            if (s1_q.fmt == FP32) begin
                s2_d.dout    = q_w;
                s2_d.shamt_h = '0;
                s2_d.shamt_l = sh_w;
                s2_d.zero_h  = 1'b0;
                s2_d.zero_l  = s1_q.zero_w;
            end else begin
                // gap bits [15:10] are forced to zero
                s2_d.dout    = {q_n[1], 6'b0, q_n[0]};
                s2_d.shamt_h = {1'b0, sh_n[1]};
                s2_d.shamt_l = {1'b0, sh_n[0]};
                s2_d.zero_h  = s1_q.zero_n[1];
                s2_d.zero_l  = s1_q.zero_n[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign dout      = s2_q.dout;
    assign shamt_h   = s2_q.shamt_h;
    assign shamt_l   = s2_q.shamt_l;
    assign zero_h    = s2_q.zero_h;
    assign zero_l    = s2_q.zero_l;
    assign sticky_h  = s2_q.sticky_h;
    assign sticky_l  = s2_q.sticky_l;
endmodule

// File: tb/tb_norm_shifter.sv
// Directed bench for norm_shifter: table of hand-computed vectors applied
// one at a time and then streamed, plus stall and reset sequences.
module tb_norm_shifter;
    import fpall_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    fp_fmt_e     fmt;
    logic [25:0] din;
    logic [7:0]  lim;
    logic        sticky_h_in, sticky_l_in;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] dout;
    logic [4:0]  shamt_h, shamt_l;
    logic        zero_h, zero_l;
    logic        sticky_h, sticky_l;

    always #5 clk = ~clk;

    norm_shifter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fmt         (fmt),
        .din         (din),
        .lim         (lim),
        .sticky_h_in (sticky_h_in),
        .sticky_l_in (sticky_l_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout),
        .shamt_h     (shamt_h),
        .shamt_l     (shamt_l),
        .zero_h      (zero_h),
        .zero_l      (zero_l),
        .sticky_h    (sticky_h),
        .sticky_l    (sticky_l)
    );

    typedef struct {
        fp_fmt_e     fmt;
        logic [25:0] din;
        logic [7:0]  lim;
        logic        sh_in;
        logic        sl_in;
        logic [25:0] e_dout;
        logic [4:0]  e_shh;
        logic [4:0]  e_shl;
        logic        e_zh;
        logic        e_zl;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input vec_t v, input string tag);
        chk({tag, ".dout"},     dout,              v.e_dout);
        chk({tag, ".shamt_h"},  26'(shamt_h),      26'(v.e_shh));
        chk({tag, ".shamt_l"},  26'(shamt_l),      26'(v.e_shl));
        chk({tag, ".zero_h"},   26'(zero_h),       26'(v.e_zh));
        chk({tag, ".zero_l"},   26'(zero_l),       26'(v.e_zl));
        chk({tag, ".sticky_h"}, 26'(sticky_h),     26'(v.sh_in));
        chk({tag, ".sticky_l"}, 26'(sticky_l),     26'(v.sl_in));
    endtask

    task automatic drive(input vec_t v);
        fmt         = v.fmt;
        din         = v.din;
        lim         = v.lim;
        sticky_h_in = v.sh_in;
        sticky_l_in = v.sl_in;
    endtask

    function automatic vec_t mk(fp_fmt_e f, logic [25:0] d, logic [7:0] l, logic sh, logic sl,
                                logic [25:0] ed, logic [4:0] eh, logic [4:0] el,
                                logic zh, logic zl);
        vec_t v;
        v.fmt = f; v.din = d; v.lim = l; v.sh_in = sh; v.sl_in = sl;
        v.e_dout = ed; v.e_shh = eh; v.e_shl = el; v.e_zh = zh; v.e_zl = zl;
        return v;
    endfunction

    initial begin
        vec_t q[$];
        vec_t seq[3];
        vec_t ev;
        int   lat, feed, got, na, stale;
        logic rdy3;

        //            fmt   din           lim    shi  sli  dout          shh shl zh zl
        vecs[0]  = mk(FP32, 26'h0001000, 8'h1F, 0, 0, 26'h2000000, 0, 13, 0, 0);
        vecs[1]  = mk(FP32, 26'h0000001, 8'h04, 1, 0, 26'h0000010, 0,  4, 0, 0);
        vecs[2]  = mk(FP16, 26'h040FC01, 8'hFF, 0, 0, 26'h2000200, 3,  9, 0, 0);
        vecs[3]  = mk(FP16, 26'h1FF0000, 8'hFF, 0, 1, 26'h3FE0000, 1,  0, 0, 1);
        vecs[4]  = mk(FP32, 26'h0000000, 8'h1F, 1, 0, 26'h0000000, 0,  0, 0, 1);
        vecs[5]  = mk(FP32, 26'h0000123, 8'h00, 0, 1, 26'h0000123, 0,  0, 0, 0);
        vecs[6]  = mk(FP32, 26'h2000000, 8'h1F, 1, 1, 26'h2000000, 0,  0, 0, 0);
        vecs[7]  = mk(FP16, 26'h001FC01, 8'h00, 0, 0, 26'h0010001, 0,  0, 0, 0);
        vecs[8]  = mk(FP16, 26'h0030005, 8'h21, 1, 0, 26'h00C000A, 2,  1, 0, 0);
        vecs[9]  = mk(FP32, 26'h0000800, 8'hE3, 0, 0, 26'h0004000, 0,  3, 0, 0);
        vecs[10] = mk(FP16, 26'h000FC00, 8'hFF, 0, 0, 26'h0000000, 0,  0, 1, 1);
        vecs[11] = mk(FP32, 26'h0000004, 8'h1F, 0, 1, 26'h2000000, 0, 23, 0, 0);
        vecs[12] = mk(FP16, 26'h2AB5555, 8'hFF, 1, 1, 26'h2AB02AA, 0,  1, 0, 0);
        vecs[13] = mk(FP16, 26'h00103FF, 8'h5F, 0, 0, 26'h02003FF, 5,  0, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fmt = FP32; din = '0; lim = '0; sticky_h_in = 1'b0; sticky_l_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // reset state
        chk("rst.out_valid", 26'(out_valid), 26'd0);
        chk("rst.in_ready",  26'(in_ready),  26'd1);
        chk("rst.dout",      dout,           26'd0);
        chk("rst.shamt",     26'({shamt_h, shamt_l}), 26'd0);
        chk("rst.flags",     26'({zero_h, zero_l, sticky_h, sticky_l}), 26'd0);

        // one transaction at a time, with latency check
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            chk($sformatf("v%0d.in_ready", i), 26'(in_ready), 26'd1);
            @(posedge clk);
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
            end while (!out_valid && lat < 8);
            chk($sformatf("v%0d.latency", i), 26'(lat), 26'd2);
            chk_out(vecs[i], $sformatf("v%0d", i));
        end

        // streamed back-to-back with periodic output stalls
        @(negedge clk);
        feed = 0; got = 0;
        for (int c = 0; c < 80 && got < NV; c++) begin
            out_ready = (c % 3) != 2;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream.unexpected", 26'd1, 26'd0);
                end else begin
                    ev = q.pop_front();
                    chk_out(ev, $sformatf("s%0d", got));
                end
                got++;
            end
            if (feed < NV) begin
                drive(vecs[feed]);
                in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(vecs[feed]);
                    feed++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream.count", 26'(got), 26'(NV));

        // three inputs against a blocked output: only two fit
        seq[0] = vecs[0]; seq[1] = vecs[2]; seq[2] = vecs[4];
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        na = 0; rdy3 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(seq[na]);
            in_valid = 1'b1;
            if (c == 2) rdy3 = in_ready;
            if (in_ready) na++;
        end
        chk("stall.accepted", 26'(na), 26'd2);
        chk("stall.in_ready", 26'(rdy3), 26'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall.out_valid", 26'(out_valid), 26'd1);
            chk("stall.hold_dout", dout, seq[0].e_dout);
            chk("stall.hold_shl",  26'(shamt_l), 26'(seq[0].e_shl));
        end
        out_ready = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (out_valid) begin
                if (got < na) chk_out(seq[got], $sformatf("rel%0d", got));
                else          chk("rel.early", 26'd1, 26'd0);
                got++;
            end
            if (na < 3) begin
                drive(seq[na]);
                in_valid = 1'b1;
                if (in_ready) na++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rel.count", 26'(got), 26'd3);

        // reset with both stages full
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        na = 0;
        for (int c = 0; c < 4 && na < 2; c++) begin
            @(negedge clk);
            drive(vecs[8 + na]);
            in_valid = 1'b1;
            if (in_ready) na++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("full.out_valid", 26'(out_valid), 26'd1);
        chk("full.in_ready",  26'(in_ready),  26'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst2.out_valid", 26'(out_valid), 26'd0);
        chk("rst2.in_ready",  26'(in_ready),  26'd1);
        chk("rst2.dout",      dout,           26'd0);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rst2.stale", 26'(stale), 26'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
endmodule

// File: doc/norm_shifter.md
NORM_SHIFTER -- requirements
Module: norm_shifter

Interface
REQ-001 SHALL import fpall_pkg; fmt uses fp_fmt_e (FP32, FP16); no parameters.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  input transaction valid.
REQ-005 SHALL have ports: in_ready  out  1  block accepts input this cycle.
REQ-006 SHALL have ports: fmt  in  fp_fmt_e  FP32 single lane / FP16 dual lane.
REQ-007 SHALL have ports: din  in  26  fraction; FP32 full width; FP16 hi lane din[25:16], gap din[15:10], lo lane din[9:0].
REQ-008 SHALL have ports: lim  in  8  max left shift; FP32 lim[4:0]; FP16 hi lim[7:4], lo lim[3:0].
REQ-009 SHALL have ports: sticky_h_in, sticky_l_in  in  1 each  sideband sticky, carried unchanged.
REQ-010 SHALL have ports: out_valid  out  1;  out_ready  in  1.
REQ-011 SHALL have ports: dout  out  26  normalized fraction, same layout as din.
REQ-012 SHALL have ports: shamt_h, shamt_l  out  5 each  applied left-shift amounts.
REQ-013 SHALL have ports: zero_h, zero_l  out  1 each  lane input all-zero.
REQ-014 SHALL have ports: sticky_h, sticky_l  out  1 each  registered copies of sideband stickies.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers inputs plus leading-zero counts; S2 registers shifted result and flags; latency 2 cycles with no stall.
REQ-016 SHALL accept a transaction when in_valid and in_ready are both 1; SHALL emit one when out_valid and out_ready are both 1.
REQ-017 SHALL advance S2 when ~s2_valid | out_ready, and S1 when ~s1_valid | S2 advance; in_ready = ~s1_valid | S1 advance, i.e. full throughput, no combinational in_valid->in_ready path.
REQ-018 SHALL hold dout, all flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 FP32: lzc = leading zeros of din[25:0] (0..25); shamt_l = min(lzc, lim[4:0]); dout = din << shamt_l with zero fill; shamt_h=0, zero_h=0.
REQ-020 FP16: each 10-bit lane independent; lzc per lane 0..9; shamt_x = min(lzc_x, lim nibble); lane shifted left within its 10 bits; no bit crosses into the gap or the other lane.
REQ-021 FP16: dout[15:10] SHALL be 0 regardless of din[15:10].
REQ-022 Zero lane (FP32 whole word, FP16 per lane): zero_x=1, shamt_x=0, lane output 0.
REQ-023 lim=0 for a lane SHALL pass that lane unshifted with shamt=0.
REQ-024 fmt, lim and stickies SHALL be captured per transaction and travel with it; a fmt change between back-to-back transactions SHALL not corrupt either.
REQ-025 A simultaneous accept and emit in the same cycle SHALL preserve order and lose no data.

Reset
REQ-026 On rst: s1_valid, s2_valid, out_valid = 0; dout, shamt_h/l, zero_h/l, sticky_h/l = 0; in_ready = 1 in the first cycle after rst deasserts.
REQ-027 rst SHALL discard in-flight transactions; none SHALL be emitted after reset.

Verification
REQ-028 FP32, din=26'h0001000, lim=8'h1F, out_ready=1 -> 2 cycles later dout=26'h2000000, shamt_l=13, zero_l=0.
REQ-029 FP32, din=26'h0000001, lim=8'h04 -> dout=26'h0000010, shamt_l=4 (limit clamp).
REQ-030 FP16, din={10'h040,6'h3F,10'h001}, lim=8'hFF -> dout=26'h2000200, shamt_h=3, shamt_l=9, gap zero.
REQ-031 FP16, din={10'h1FF,6'h0,10'h000}, sticky_l_in=1 -> dout={10'h3FE,6'h0,10'h000}, shamt_h=1, zero_l=1, shamt_l=0, sticky_l=1.
REQ-032 Three back-to-back inputs with out_ready=0 -> only two accepted, in_ready=0 on third; release out_ready -> all three outputs in order, each held until accepted.
REQ-033 rst pulsed with both stages valid -> next cycle out_valid=0, in_ready=1; no stale output afterwards.
